// File: rtl/stroke_replay_ctrl_if.sv
// Segment handshake between the stroke replay controller and a draw_line
// style rasteriser.
//   seg_valid  master->slave  segment on X1..Y2 is valid
//   seg_ready  slave->master  rasteriser accepts (transfer on valid & ready)
//   X1,Y1      master->slave  segment start point
//   X2,Y2      master->slave  segment end point
interface stroke_replay_ctrl_if #(
    parameter int CW = 16
);
    logic          seg_valid;
    logic          seg_ready;
    logic [CW-1:0] X1;
    logic [CW-1:0] Y1;
    logic [CW-1:0] X2;
    logic [CW-1:0] Y2;

    modport master (output seg_valid, X1, Y1, X2, Y2, input seg_ready);
    modport slave  (input seg_valid, X1, Y1, X2, Y2, output seg_ready);
endinterface

// File: rtl/stroke_replay_ctrl.sv
// Stroke replay controller. Keeps the last DEPTH detected pen points (tagged
// with a pen-up flag) in a ring buffer and, on each end-of-frame, replays the
// stored shape as line segments (polyline / rectangle / triangle) over a
// valid/ready handshake.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_mode          0/3 polyline, 1 rectangle, 2 triangle
//   i_detect        point strobe with i_X_pos / i_Y_pos
//   i_end_frame     end-of-frame strobe, starts a replay when idle
//   i_clear         flush buffer and gap counter, aborts a replay
//   seg             segment handshake (master side)
//   o_replay_busy   replay in progress
//   o_replay_done   pulse after the last segment of a replay
//   o_count         stored points, saturates at DEPTH
//   o_overrun       pulse when i_end_frame arrives during a replay
module stroke_replay_ctrl #(
    parameter int DEPTH      = 8,
    parameter int CW         = 16,
    parameter int GAP_FRAMES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 i_mode,
    input  logic                       i_detect,
    input  logic [CW-1:0]              i_X_pos,
    input  logic [CW-1:0]              i_Y_pos,
    input  logic                       i_end_frame,
    input  logic                       i_clear,
    stroke_replay_ctrl_if.master       seg,
    output logic                       o_replay_busy,
    output logic                       o_replay_done,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overrun
);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int SW   = CNTW + 1;
    localparam int GW   = $clog2(GAP_FRAMES + 1);

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          pu;
    } point_t;

    typedef enum logic [1:0] {M_POLY, M_RECT, M_TRI} mode_e;
    typedef enum logic {S_IDLE, S_REPLAY} state_e;

    // storage side
    point_t          r_buf [DEPTH];
    logic [IW-1:0]   r_head;
    logic [CNTW-1:0] r_count;
    logic [GW-1:0]   r_gap;
    logic            r_first;

    // replay side: snapshot is stored oldest-first so replay never wraps
    point_t          r_snap [DEPTH];
    logic [CNTW-1:0] r_rcnt;
    logic [CNTW-1:0] r_k;
    logic [1:0]      r_seg;
    mode_e           r_mode;
    state_e          r_state, w_state_nxt;
    logic            r_done, r_overrun;

    logic            w_wr, w_start, w_hs;
    point_t          w_pt;
    logic [IW-1:0]   w_head_post, w_tail;
    logic [CNTW-1:0] w_cnt_post;
    logic [SW-1:0]   w_tail_sum;
    point_t          w_snap [DEPTH];

    logic [DEPTH-1:0] w_cand;
    logic             w_pfound, w_pmore;
    logic [IW-1:0]    w_pidx;
    point_t           w_n1, w_n2, w_n3, w_p0, w_p1;
    logic             w_cur_v, w_last;
    logic [CW-1:0]    w_sx1, w_sy1, w_sx2, w_sy2;

    function automatic logic [IW-1:0] ring_idx(input logic [IW-1:0] base, input int ofs);
        logic [SW-1:0] s;
        s = SW'(base) + SW'(ofs);
        if (s >= SW'(DEPTH)) s = s - SW'(DEPTH);
        return IW'(s);
    endfunction

    // ------------------------------------------------------------ write path
    assign w_wr = i_detect & ~i_clear;
    assign w_pt = '{x: i_X_pos, y: i_Y_pos, pu: r_first | (r_gap >= GW'(GAP_FRAMES))};

    always_comb begin
        w_head_post = r_head;
        w_cnt_post  = r_count;
        if (w_wr) begin
            w_head_post = (r_head == IW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
            if (r_count != CNTW'(DEPTH)) w_cnt_post = r_count + 1'b1;
        end
    end

    // Oldest entry after this cycle's write; head < DEPTH and count <= DEPTH
    // so one conditional subtract is enough for the modulo.
    assign w_tail_sum = SW'(w_head_post) + SW'(DEPTH) - SW'(w_cnt_post);
    assign w_tail     = (w_tail_sum >= SW'(DEPTH)) ? IW'(w_tail_sum - SW'(DEPTH)) : IW'(w_tail_sum);

    // Linearised post-write view of the ring: a point written in the
    // end-of-frame cycle is forwarded so it is part of this replay.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr && ring_idx(w_tail, i) == r_head) w_snap[i] = w_pt;
            else                                       w_snap[i] = r_buf[ring_idx(w_tail, i)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_head  <= '0;
            r_count <= '0;
            r_gap   <= '0;
            r_first <= 1'b1;
        end else if (i_clear) begin
            r_head  <= '0;
            r_count <= '0;
            r_gap   <= '0;
            r_first <= 1'b1;
        end else begin
            if (w_wr) begin
                r_buf[r_head] <= w_pt;
                r_first       <= 1'b0;
            end
            r_head  <= w_head_post;
            r_count <= w_cnt_post;
            // detect beats end_frame on the gap counter
            if (i_detect)
                r_gap <= '0;
            else if (i_end_frame && r_gap < GW'(GAP_FRAMES))
                r_gap <= r_gap + 1'b1;
        end
    end

    // ----------------------------------------------------------- replay path
    assign w_start = (r_state == S_IDLE) & i_end_frame & ~i_clear;
    assign w_hs    = (r_state == S_REPLAY) & w_cur_v & seg.seg_ready;

    // Polyline: candidate end points k >= r_k that are drawable; index 0 is
    // never a candidate, which makes the oldest point behave as pen-up.
    always_comb begin
        w_cand = '0;
        for (int k = 1; k < DEPTH; k++)
            w_cand[k] = (CNTW'(k) < r_rcnt) && (CNTW'(k) >= r_k) && !r_snap[k].pu;
        w_pfound = 1'b0;
        w_pmore  = 1'b0;
        w_pidx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_cand[k]) begin
                if (w_pfound) w_pmore = 1'b1;
                else begin
                    w_pfound = 1'b1;
                    w_pidx   = IW'(k);
                end
            end
        end
    end

    assign w_p1 = r_snap[w_pidx];
    assign w_p0 = r_snap[w_pidx - 1'b1];
    assign w_n1 = r_snap[IW'(r_rcnt - CNTW'(1))];
    assign w_n2 = r_snap[IW'(r_rcnt - CNTW'(2))];
    assign w_n3 = r_snap[IW'(r_rcnt - CNTW'(3))];

    always_comb begin
        w_cur_v = 1'b0;
        w_last  = 1'b0;
        w_sx1   = '0;
        w_sy1   = '0;
        w_sx2   = '0;
        w_sy2   = '0;
        case (r_mode)
            M_RECT: begin
                w_cur_v = (r_rcnt >= CNTW'(2));
                w_last  = (r_seg == 2'd3);
                case (r_seg)
                    2'd0:    {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n2.x, w_n2.y, w_n1.x, w_n2.y};
                    2'd1:    {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n1.x, w_n2.y, w_n1.x, w_n1.y};
                    2'd2:    {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n1.x, w_n1.y, w_n2.x, w_n1.y};
                    default: {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n2.x, w_n1.y, w_n2.x, w_n2.y};
                endcase
            end
            M_TRI: begin
                w_cur_v = (r_rcnt >= CNTW'(3)) && (r_seg != 2'd3);
                w_last  = (r_seg == 2'd2);
                case (r_seg)
                    2'd0:    {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n3.x, w_n3.y, w_n2.x, w_n2.y};
                    2'd1:    {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n2.x, w_n2.y, w_n1.x, w_n1.y};
                    default: {w_sx1, w_sy1, w_sx2, w_sy2} = {w_n1.x, w_n1.y, w_n3.x, w_n3.y};
                endcase
            end
            default: begin
                w_cur_v = w_pfound;
                w_last  = ~w_pmore;
                {w_sx1, w_sy1, w_sx2, w_sy2} = {w_p0.x, w_p0.y, w_p1.x, w_p1.y};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_snap[i] <= '0;
            r_rcnt <= '0;
            r_k    <= '0;
            r_seg  <= '0;
            r_mode <= M_POLY;
        end else if (w_start) begin
            for (int i = 0; i < DEPTH; i++) r_snap[i] <= w_snap[i];
            r_rcnt <= w_cnt_post;
            r_k    <= CNTW'(1);
            r_seg  <= '0;
            r_mode <= (i_mode == 2'd1) ? M_RECT : (i_mode == 2'd2) ? M_TRI : M_POLY;
        end else if (w_hs) begin
            r_k   <= CNTW'(w_pidx) + 1'b1;
            r_seg <= r_seg + 1'b1;
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // a clear-induced exit is an abort, not a completion
            r_done    <= (r_state == S_REPLAY) && !i_clear && (w_state_nxt == S_IDLE);
            r_overrun <= (r_state == S_REPLAY) && i_end_frame;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_REPLAY;
            S_REPLAY: if (i_clear || !w_cur_v || (seg.seg_ready && w_last)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        seg.seg_valid = 1'b0;
        seg.X1        = '0;
        seg.Y1        = '0;
        seg.X2        = '0;
        seg.Y2        = '0;
        o_replay_busy = (r_state == S_REPLAY);
        if (r_state == S_REPLAY && w_cur_v) begin
            seg.seg_valid = 1'b1;
            seg.X1        = w_sx1;
            seg.Y1        = w_sy1;
            seg.X2        = w_sx2;
            seg.Y2        = w_sy2;
        end
    end

    assign o_count       = r_count;
    assign o_replay_done = r_done;
    assign o_overrun     = r_overrun;
endmodule
